core_seq_ctrl: RTL

- Per-tile sequencer for the systolic core.
- Generates the registered 34-bit core instruction word each cycle, plus `mode` and the output-bank `sel`, for one tile. A tile is:
  - load `row` weight vectors from xmem into the array;
  - stream `nij` activation vectors through execute;
  - drain `nij` OFIFO results into the selected pmem bank.
- Sits between the host/testbench command interface and the core. It replaces hand-written instruction streams.

---
 rtl/core_seq_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl
// Per-tile sequencer for the systolic core. It emits one registered 34-bit
// core instruction word per cycle. A tile loads `row` weight vectors, streams
// `nij` activation vectors through execute, then drains `nij` OFIFO results
// into the selected pmem bank.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle tile start, only sampled in IDLE
//   cfg_w_base          xmem address of the first weight vector
//   cfg_x_base          xmem address of the first activation vector
//   cfg_p_base          pmem address of the first output
//   cfg_nij             activation/output count
//   cfg_mode            0 = 2-bit, 1 = 4-bit (latched into mode)
//   cfg_acc             value driven on inst[33] during pmem writes
//   ofifo_valid         core OFIFO holds a full output vector
//   inst                core instruction word
//   mode, sel           latched mode, pmem bank select
//   busy, done          tile in progress, one-cycle end-of-tile pulse
//
// Instruction word: [33] acc, [32] CEN_pmem_n, [31] WEN_pmem_n,
// [30:20] A_pmem, [19] CEN_xmem_n, [18] WEN_xmem_n, [17:7] A_xmem,
// [6] ofifo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; inst holds the idle word
// WLOAD   | reading row weight vectors from xmem into L0 / array
// WSETTLE | row+1 cycles letting weights propagate through the array
// XEXEC   | streaming nij activation vectors with execute
// DRD     | ofifo_rd pulse for output d
// DWR     | pmem write of output d
// DWAIT   | OFIFO empty, idle word held until ofifo_valid
// DONE    | done pulse, sel toggled, back to IDLE next
module core_seq_ctrl #(
  parameter int row    = 2,
  parameter int col    = 2,
  parameter int addr_w = 11,
  parameter int cnt_w  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] cfg_w_base,
  input  logic [addr_w-1:0] cfg_x_base,
  input  logic [addr_w-1:0] cfg_p_base,
  input  logic [cnt_w-1:0]  cfg_nij,
  input  logic              cfg_mode,
  input  logic              cfg_acc,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic              mode,
  output logic              sel,
  output logic              busy,
  output logic              done
);

  if (row < 1 || col < 1) begin : g_bad_geometry
    $error("core_seq_ctrl: row and col must be at least 1");
  end

  localparam logic [33:0]      IDLE_INST   = 34'h1800C0000;
  localparam logic [cnt_w-1:0] LAST_ROW    = cnt_w'(row - 1);
  localparam logic [cnt_w-1:0] LAST_SETTLE = cnt_w'(row);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WSETTLE, S_XEXEC, S_DRD, S_DWR, S_DWAIT, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [cnt_w-1:0]  cnt, cnt_n;
  logic [cnt_w-1:0]  d_cnt, d_cnt_n;
  logic [addr_w-1:0] w_base, w_base_n;
  logic [addr_w-1:0] x_base, x_base_n;
  logic [addr_w-1:0] p_base, p_base_n;
  logic [cnt_w-1:0]  nij, nij_n;
  logic              acc, acc_n;
  logic              mode_n, sel_n;
  logic [addr_w-1:0] a_w, a_x, a_p;
  logic [33:0]       inst_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      d_cnt  <= '0;
      w_base <= '0;
      x_base <= '0;
      p_base <= '0;
      nij    <= '0;
      acc    <= 1'b0;
      inst   <= IDLE_INST;
      mode   <= 1'b0;
      sel    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      d_cnt  <= d_cnt_n;
      w_base <= w_base_n;
      x_base <= x_base_n;
      p_base <= p_base_n;
      nij    <= nij_n;
      acc    <= acc_n;
      inst   <= inst_n;
      mode   <= mode_n;
      sel    <= sel_n;
      busy   <= (state_n != S_IDLE);
      done   <= (state_n == S_DONE);
    end
  end

  // Next-state logic. The registered inst/done/busy describe the state being
  // entered, so every output is derived from the *_n values.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    d_cnt_n  = d_cnt;
    w_base_n = w_base;
    x_base_n = x_base;
    p_base_n = p_base;
    nij_n    = nij;
    acc_n    = acc;
    mode_n   = mode;
    case (state)
      S_IDLE: begin
        if (start) begin
          w_base_n = cfg_w_base;
          x_base_n = cfg_x_base;
          p_base_n = cfg_p_base;
          nij_n    = cfg_nij;
          acc_n    = cfg_acc;
          mode_n   = cfg_mode;
          cnt_n    = '0;
          d_cnt_n  = '0;
          state_n  = S_WLOAD;
        end
      end
      S_WLOAD: begin
        if (cnt == LAST_ROW) begin
          cnt_n   = '0;
          state_n = (nij == '0) ? S_DONE : S_WSETTLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WSETTLE: begin
        if (cnt == LAST_SETTLE) begin
          cnt_n   = '0;
          state_n = S_XEXEC;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_XEXEC: begin
        if (cnt == nij - 1'b1) begin
          cnt_n   = '0;
          d_cnt_n = '0;
          state_n = ofifo_valid ? S_DRD : S_DWAIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRD: state_n = S_DWR;
      S_DWR: begin
        if (d_cnt == nij - 1'b1) begin
          state_n = S_DONE;
        end else begin
          d_cnt_n = d_cnt + 1'b1;
          state_n = ofifo_valid ? S_DRD : S_DWAIT;
        end
      end
      S_DWAIT: begin
        if (ofifo_valid) state_n = S_DRD;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // DONE is only ever entered from WLOAD or DWR, so this flips sel once.
    sel_n = sel ^ (state_n == S_DONE);
  end

  assign a_w = w_base_n + addr_w'(cnt_n);
  assign a_x = x_base_n + addr_w'(cnt_n);
  assign a_p = p_base_n + addr_w'(d_cnt_n);

  always_comb begin
    inst_n = IDLE_INST;
    case (state_n)
      S_WLOAD: begin
        inst_n[19]   = 1'b0;
        inst_n[17:7] = 11'(a_w);
        inst_n[2]    = 1'b1;
        inst_n[0]    = 1'b1;
      end
      S_WSETTLE: begin
        inst_n[3] = 1'b1;
        inst_n[0] = 1'b1;
      end
      S_XEXEC: begin
        inst_n[19]   = 1'b0;
        inst_n[17:7] = 11'(a_x);
        inst_n[3]    = 1'b1;
        inst_n[2]    = 1'b1;
        inst_n[1]    = 1'b1;
      end
      S_DRD: inst_n[6] = 1'b1;
      S_DWR: begin
        inst_n[33]    = acc_n;
        inst_n[32]    = 1'b0;
        inst_n[31]    = 1'b0;
        inst_n[30:20] = 11'(a_p);
      end
      default: inst_n = IDLE_INST;
    endcase
  end

endmodule
